// File: rtl/tcb_pkg.sv
// Shared TCB definitions: default bus widths, the response record carried
// through the response pipeline, and a byte-enable to bit-mask helper.
package tcb_pkg;

  localparam int unsigned TCB_ABW = 32;
  localparam int unsigned TCB_DBW = 32;
  localparam int unsigned TCB_SLW = 8;
  localparam int unsigned TCB_BEW = TCB_DBW / TCB_SLW;

  typedef struct packed {
    logic [TCB_DBW-1:0] rdt;
    logic               err;
  } tcb_rsp_t;

  // Each set byte-enable bit opens its SLW-wide lane in the returned mask.
  function automatic logic [TCB_DBW-1:0] tcb_ben2mask(input logic [TCB_BEW-1:0] ben);
    logic [TCB_DBW-1:0] mask;
    mask = '0;
    for (int unsigned b = 0; b < TCB_BEW; b++) begin
      mask[TCB_SLW*b +: TCB_SLW] = {TCB_SLW{ben[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/tcb_rsp_dly.sv
// Response delay line for tcb_sub_mem.
//   clk, rst   clock, asynchronous active-low reset
//   vld, rsp   response entering the line in the transfer cycle
//   dly_vld,   response leaving the line DLY cycles later
//   dly_rsp    (DLY=0: combinational pass-through)
module tcb_rsp_dly
  import tcb_pkg::*;
#(
  parameter int unsigned DLY = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     vld,
  input  tcb_rsp_t rsp,
  output logic     dly_vld,
  output tcb_rsp_t dly_rsp
);

  generate
    if (DLY == 0) begin : g_pass
      assign dly_vld = vld;
      assign dly_rsp = rsp;
    end else begin : g_pipe
      logic [DLY-1:0] vld_q;
      tcb_rsp_t       rsp_q [DLY];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_q <= '0;
          for (int unsigned i = 0; i < DLY; i++) rsp_q[i] <= '0;
        end else begin
          vld_q[0] <= vld;
          rsp_q[0] <= rsp;
          for (int unsigned i = 1; i < DLY; i++) begin
            vld_q[i] <= vld_q[i-1];
            rsp_q[i] <= rsp_q[i-1];
          end
        end
      end

      assign dly_vld = vld_q[DLY-1];
      assign dly_rsp = rsp_q[DLY-1];
    end
  endgenerate

endmodule

// File: rtl/tcb_sub_mem.sv
// TCB subordinate memory with optional wait states and response delay.
//   clk, rst        clock, asynchronous active-low reset
//   tcb_vld/rdy     handshake; transfer when both are high at a rising edge
//   tcb_wen         write enable
//   tcb_adr         byte address (must be word aligned and inside memory)
//   tcb_ben         byte enables for writes
//   tcb_wdt         write data
//   tcb_lck         arbitration lock, ignored
//   tcb_rpt         repeat access: skips wait states when re-hitting last address
//   tcb_rdt/err     response, DLY cycles after the transfer, zero when idle
module tcb_sub_mem
  import tcb_pkg::*;
#(
  parameter int unsigned ABW = TCB_ABW,
  parameter int unsigned DBW = TCB_DBW,
  parameter int unsigned SLW = TCB_SLW,
  parameter int unsigned BEW = DBW / SLW,
  parameter int unsigned DLY = 1,
  parameter int unsigned MSZ = 256,
  parameter int unsigned WST = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tcb_vld,
  input  logic           tcb_wen,
  input  logic [ABW-1:0] tcb_adr,
  input  logic [BEW-1:0] tcb_ben,
  input  logic [DBW-1:0] tcb_wdt,
  input  logic           tcb_lck,
  input  logic           tcb_rpt,
  output logic [DBW-1:0] tcb_rdt,
  output logic           tcb_err,
  output logic           tcb_rdy
);

  localparam int unsigned OFW = $clog2(BEW);
  localparam int unsigned IDW = $clog2(MSZ);
  localparam logic [ABW:0] LIM = (ABW+1)'(MSZ * BEW);

  logic [3:0]     cnt;
  logic [ABW-1:0] lst_adr;
  logic           lst_vld;
  logic           hit;
  logic           trn;
  logic           err;
  logic [IDW-1:0] idx;
  logic [DBW-1:0] msk;
  logic [DBW-1:0] mem [MSZ];
  tcb_rsp_t       rsp;
  logic           dly_vld;
  tcb_rsp_t       dly_rsp;
  logic           unused_lck;

  assign unused_lck = tcb_lck;

  // Gated by rst so the bus sees rdy=0 throughout reset even with WST=0.
  assign hit     = lst_vld & (tcb_adr == lst_adr);
  assign tcb_rdy = rst & ((cnt == 4'(WST)) | (tcb_rpt & hit));
  assign trn     = tcb_vld & tcb_rdy;

  assign err = ({1'b0, tcb_adr} >= LIM) | (tcb_adr[OFW-1:0] != '0);
  assign idx = tcb_adr[OFW +: IDW];
  assign msk = tcb_ben2mask(tcb_ben);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      lst_adr <= '0;
      lst_vld <= 1'b0;
    end else begin
      if (trn) begin
        cnt     <= '0;
        lst_adr <= tcb_adr;
        lst_vld <= 1'b1;
      end else if (tcb_vld) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (trn & tcb_wen & ~err) begin
      mem[idx] <= (mem[idx] & ~msk) | (tcb_wdt & msk);
    end
  end

  always_comb begin
    rsp = '0;
    if (trn) begin
      rsp.err = err;
      if (~tcb_wen & ~err) rsp.rdt = mem[idx];
    end
  end

  tcb_rsp_dly #(
    .DLY (DLY)
  ) u_rsp_dly (
    .clk     (clk),
    .rst     (rst),
    .vld     (trn),
    .rsp     (rsp),
    .dly_vld (dly_vld),
    .dly_rsp (dly_rsp)
  );

  assign tcb_rdt = dly_vld ? dly_rsp.rdt : '0;
  assign tcb_err = dly_vld & dly_rsp.err;

endmodule
